// File: rtl/adder8_arbiter.sv
// Two-requester front end for a single shared 8-bit adder: round-robin grant,
// registered operands and result, result held until the consumer accepts it.

module eightbit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] f,
    output logic       ovf
);

    always_comb begin
        f   = a + b;
        // Signed overflow: operands agree in sign but the sum does not.
        ovf = (a[7] == b[7]) && (f[7] != a[7]);
    end

endmodule

module adder8_arbiter #(
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [7:0]           req0_a,
    input  logic [7:0]           req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [7:0]           req1_a,
    input  logic [7:0]           req1_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [7:0]           resp_f,
    output logic                 resp_ovf,
    output logic                 busy,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       last_grant_q;
    logic       id_q;
    logic [7:0] op_a_q;
    logic [7:0] op_b_q;
    logic       grant_valid;
    logic       grant_id;
    logic [7:0] sum_f;
    logic       sum_ovf;

    eightbit_adder u_adder (
        .a   (op_a_q),
        .b   (op_b_q),
        .f   (sum_f),
        .ovf (sum_ovf)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant_valid = 1'b1;
                    grant_id    = ~last_grant_q;
                end else if (req0_valid) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b0;
                end else if (req1_valid) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end
                req0_ready = grant_valid && !grant_id;
                req1_ready = grant_valid && grant_id;
                if (grant_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_a_q       <= 8'h00;
            op_b_q       <= 8'h00;
            resp_valid   <= 1'b0;
            resp_id      <= 1'b0;
            resp_f       <= 8'h00;
            resp_ovf     <= 1'b0;
            ovf_count    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        op_a_q       <= grant_id ? req1_a : req0_a;
                        op_b_q       <= grant_id ? req1_b : req0_b;
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                    end
                end
                EXEC: begin
                    resp_f     <= sum_f;
                    resp_ovf   <= sum_ovf;
                    resp_id    <= id_q;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (resp_ovf && (ovf_count != '1)) begin
                            ovf_count <= ovf_count + 1'b1;
                        end
                    end
                end
                default: resp_valid <= 1'b0;
            endcase
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_adder8_arbiter.sv
// Directed bench for adder8_arbiter: a transaction-level reference model checked
// every cycle, plus literal expectations for the scenarios worked out by hand.

module tb_adder8_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_a = 8'h00;
    logic [7:0] req0_b = 8'h00;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_a = 8'h00;
    logic [7:0] req1_b = 8'h00;
    logic       resp_ready = 1'b0;

    logic       req0_ready, req1_ready, resp_valid, resp_id, resp_ovf, busy;
    logic [7:0] resp_f;
    logic [7:0] ovf_count;

    logic       d2_req0_ready, d2_req1_ready, d2_resp_valid, d2_resp_id, d2_resp_ovf, d2_busy;
    logic [7:0] d2_resp_f;
    logic [1:0] d2_ovf_count;

    int n_checks = 0;
    int n_errors = 0;

    adder8_arbiter u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_f(resp_f), .resp_ovf(resp_ovf), .busy(busy), .ovf_count(ovf_count)
    );

    adder8_arbiter #(.OVF_CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(d2_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(d2_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(d2_resp_valid), .resp_ready(resp_ready), .resp_id(d2_resp_id),
        .resp_f(d2_resp_f), .resp_ovf(d2_resp_ovf), .busy(d2_busy), .ovf_count(d2_ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic logic [1:0] pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return {1'b1, ~last};
        if (v0) return 2'b10;
        if (v1) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic ref_ovf(input int a, input int b);
        int sa;
        int sb;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        return ((sa + sb) > 127) || ((sa + sb) < -128);
    endfunction

    logic       m_known = 1'b0;
    logic       m_busy  = 1'b0;
    logic       m_age   = 1'b0;
    logic       m_id    = 1'b0;
    logic       m_last  = 1'b1;
    logic [7:0] m_f     = 8'h00;
    logic       m_ovf   = 1'b0;
    int         m_cnt8  = 0;
    int         m_cnt2  = 0;

    always @(posedge clk) begin
        logic [1:0] g;
        int a;
        int b;
        g = pick(req0_valid, req1_valid, m_last);
        a = g[0] ? int'(req1_a) : int'(req0_a);
        b = g[0] ? int'(req1_b) : int'(req0_b);
        if (rst) begin
            m_known <= 1'b1;
            m_busy  <= 1'b0;
            m_age   <= 1'b0;
            m_last  <= 1'b1;
            m_cnt8  <= 0;
            m_cnt2  <= 0;
        end else if (m_known) begin
            if (m_busy) begin
                if (m_age && resp_ready) begin
                    m_busy <= 1'b0;
                    if (m_ovf) begin
                        m_cnt8 <= (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                        m_cnt2 <= (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
                    end
                end else begin
                    m_age <= 1'b1;
                end
            end else if (g[1]) begin
                m_busy <= 1'b1;
                m_age  <= 1'b0;
                m_id   <= g[0];
                m_last <= g[0];
                m_f    <= 8'((a + b) % 256);
                m_ovf  <= ref_ovf(a, b);
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] g;
        logic       exp_rv;
        if (m_known) begin
            g      = pick(req0_valid, req1_valid, m_last);
            exp_rv = m_busy && m_age;
            check("req0_ready", req0_ready, !m_busy && g[1] && !g[0]);
            check("req1_ready", req1_ready, !m_busy && g[1] && g[0]);
            check("resp_valid", resp_valid, exp_rv);
            check("busy", busy, m_busy);
            check("ovf_count", ovf_count, m_cnt8);
            check("d2_ovf_count", d2_ovf_count, m_cnt2);
            check("d2_resp_valid", d2_resp_valid, exp_rv);
            if (exp_rv) begin
                check("resp_id", resp_id, m_id);
                check("resp_f", resp_f, m_f);
                check("resp_ovf", resp_ovf, m_ovf);
                check("d2_resp_f", d2_resp_f, m_f);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Presents operands on one requester and returns one step after the accept edge.
    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b);
        logic got;
        got = 1'b0;
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                got = 1'b1;
                break;
            end
        end
        check("grant_timeout", got, 1'b1);
        tick();
        if (id == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    // Waits for the result (cycles counted from the accept edge) and lets it be delivered.
    task automatic expect_resp(input logic id, input logic [7:0] f, input logic ovf, input int lat);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                n   = i;
                got = 1'b1;
                break;
            end
        end
        check("resp_timeout", got, 1'b1);
        if (lat > 0) check("latency", n, lat);
        check("lit_resp_id", resp_id, id);
        check("lit_resp_f", resp_f, f);
        check("lit_resp_ovf", resp_ovf, ovf);
        tick();
    endtask

    initial begin
        int ids[$];
        int cyc[$];
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ids[$];
        int cyc[$];

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_f", resp_f, 8'h00);
        check("rst_resp_id", resp_id, 1'b0);
        check("rst_resp_ovf", resp_ovf, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf_count", ovf_count, 8'h00);
        #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        tick();

        // Basic add, latency two cycles after accept
        issue(0, 8'h05, 8'h03);
        expect_resp(1'b0, 8'h08, 1'b0, 2);
        check("cnt_after_basic", ovf_count, 8'd0);

        // Overflow cases and plain carry wrap
        issue(1, 8'h7F, 8'h01);
        expect_resp(1'b1, 8'h80, 1'b1, 2);
        issue(0, 8'h80, 8'h80);
        expect_resp(1'b0, 8'h00, 1'b1, 2);
        issue(0, 8'hFF, 8'h01);
        expect_resp(1'b0, 8'h00, 1'b0, 2);
        check("cnt_after_ovf", ovf_count, 8'd2);
        check("d2_cnt_after_ovf", d2_ovf_count, 2'd2);

        // Round robin with both requesters valid continuously
        do_reset();
        req0_a = 8'h01; req0_b = 8'h02;
        req1_a = 8'h0A; req1_b = 8'h14;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                ids.push_back(int'(resp_id));
                cyc.push_back(i);
            end
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        expect_resp(1'b0, 8'h03, 1'b0, 0);
        check("rr_count", ids.size(), 4);
        if (ids.size() == 4) begin
            check("rr_id0", ids[0], 0);
            check("rr_id1", ids[1], 1);
            check("rr_id2", ids[2], 0);
            check("rr_id3", ids[3], 1);
            check("rr_first_cycle", cyc[0], 2);
            check("rr_gap", cyc[3] - cyc[0], 9);
        end

        // Backpressure for 10 cycles while both requesters wait
        resp_ready = 1'b0;
        issue(0, 8'h11, 8'h22);
        req0_a = 8'h40; req0_b = 8'h01;
        req1_a = 8'h05; req1_b = 8'h06;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_resp_valid", resp_valid, 1'b1);
            check("bp_resp_f", resp_f, 8'h33);
            check("bp_req0_ready", req0_ready, 1'b0);
            check("bp_req1_ready", req1_ready, 1'b0);
            check("bp_busy", busy, 1'b1);
        end
        tick();
        resp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_next_req1_ready", req1_ready, 1'b1);
        check("bp_next_req0_ready", req0_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        expect_resp(1'b1, 8'h0B, 1'b0, 2);

        // Reset during EXEC aborts the operation and restores grant priority
        do_reset();
        issue(0, 8'h7F, 8'h7F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_resp_valid", resp_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ovf_count", ovf_count, 8'd0);
        #1;
        req0_a = 8'h01; req0_b = 8'h01;
        req1_a = 8'h02; req1_b = 8'h02;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("abort_req0_ready", req0_ready, 1'b1);
        check("abort_req1_ready", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        expect_resp(1'b0, 8'h02, 1'b0, 2);

        // Saturation of the narrow counter
        for (int i = 0; i < 5; i++) begin
            issue(i % 2, 8'h80, 8'h80);
            expect_resp(1'(i % 2), 8'h00, 1'b1, 2);
        end
        tick();
        check("sat_cnt8", ovf_count, 8'd5);
        check("sat_cnt2", d2_ovf_count, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder8_arbiter.md
Name: adder8_arbiter

Overview:
- Shares a single combinational eightbit_adder instance between two requesters using valid/ready handshakes with round-robin arbitration.
- Registers operands and results, holds each result until the consumer accepts it, and keeps a saturating count of overflowed additions.
- Sits between the requester logic (switch/test-pattern sources or upstream controllers) and the LED/result sink.
- Only one addition is in flight at any time.

Parameters:
- OVF_CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has operands.
- req0_ready  output  1  requester 0 operands are accepted this cycle.
- req0_a  input  8  requester 0 operand a.
- req0_b  input  8  requester 0 operand b.
- req1_valid  input  1  requester 1 has operands.
- req1_ready  output  1  requester 1 operands are accepted this cycle.
- req1_a  input  8  requester 1 operand a.
- req1_b  input  8  requester 1 operand b.
- resp_valid  output  1  result is held on the resp_* outputs.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  1  index of the requester that owns the result.
- resp_f  output  8  sum, a+b mod 256.
- resp_ovf  output  1  ovf flag from eightbit_adder; signed two's-complement overflow.
- busy  output  1  high when the state is not IDLE.
- ovf_count  output  OVF_CNT_W  number of delivered results with resp_ovf=1; saturates at all-ones.

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high on rst. A reset forces every register at the next edge.
- Reset values: state=IDLE, last_grant=1, resp_valid=0, resp_id=0, resp_f=0x00, resp_ovf=0, ovf_count=0, operand registers=0.
- Adder connection: eightbit_adder is instantiated once. Its inputs are driven only from the internal operand registers op_a/op_b, never directly from the req ports.
- IDLE state:
  - req0_ready and req1_ready are combinational and are driven only in IDLE.
  - Only one requester valid: that requester's ready=1.
  - Both valid: grant goes to the requester != last_grant; only the granted ready=1.
  - Neither valid: both ready=0.
  - Both ready signals are 0 in every other state.
- Accept (IDLE, granted valid&ready at edge N):
  - op_a/op_b are loaded from the granted requester.
  - id_reg and last_grant are set to the granted index.
  - state goes to EXEC.
- EXEC (edge N+1):
  - resp_f is loaded from the adder f output and resp_ovf from the adder ovf output.
  - resp_id is loaded from id_reg, resp_valid is set to 1, and state goes to RESP.
  - Latency: resp_valid is high in the cycle after edge N+1, two cycles after the accept cycle.
- RESP state:
  - resp_* outputs stay stable while resp_valid=1 and resp_ready=0. Backpressure may last indefinitely.
  - On an edge with resp_ready=1: resp_valid goes to 0 and state goes to IDLE.
  - At the same edge, if resp_ovf=1 and ovf_count is not all-ones, ovf_count increments by 1.
  - The earliest next accept is the cycle after returning to IDLE, so back-to-back throughput is one result per 3 cycles.
- Arithmetic:
  - resp_f = (a+b) mod 256.
  - resp_ovf = 1 when a[7]==b[7] and f[7]!=a[7]; otherwise 0.
  - Carry-out is not reported.
- Boundaries:
  - Requester inputs that change while not ready are ignored.
  - A requester that drops valid before grant loses nothing; no state is kept for it.
  - resp_ready while resp_valid=0 is ignored.
  - ovf_count holds at 2^OVF_CNT_W-1 once saturated.
  - rst in EXEC or RESP aborts the in-flight operation. The result is discarded, and the first grant after reset goes to requester 0.
- State encoding: IDLE/EXEC/RESP encoding is free; no illegal-state output glitches are allowed. Unused encodings return to IDLE.

Test Plan:
- Reset, then req0 issues 0x05+0x03 with resp_ready=1 → resp_valid high 2 cycles after accept; resp_id=0, resp_f=0x08, resp_ovf=0, ovf_count=0.
- req1 issues 0x7F+0x01, then req0 issues 0x80+0x80 → 0x80/ovf=1 followed by 0x00/ovf=1; ovf_count=2. Also 0xFF+0x01 → 0x00, ovf=0.
- Both requesters valid continuously with resp_ready=1 → grant order 0,1,0,1; resp_id alternates; one result every 3 cycles; the non-granted ready stays 0.
- resp_ready held 0 for 10 cycles with new req0/req1 valid → resp_* stable, both ready=0, busy=1; release resp_ready → next grant proceeds.
- rst asserted in EXEC after an accepted 0x7F+0x7F → resp_valid=0 and ovf_count=0 after the edge; the following simultaneous request grants req0 first.
- Force ovf_count to saturation (OVF_CNT_W=2, 5 overflowing adds) → ovf_count sticks at 3.
